// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
// Global-history branch predictor for the fetch stage. A global history
// register (GHR) is combined with the fetch PC to index a table of 2-bit
// saturating counters. The GHR is shifted speculatively at prediction time
// and restored from the checkpoint carried with a mispredicted branch.
// After reset a sweep FSM fills the table with weakly-not-taken counters.
// Predictions are accepted only once the sweep has finished.

module gshare_branch_predictor #(
    parameter int PC_W   = 16,
    parameter int HIST_W = 4,
    parameter int IDX_W  = 4,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              pred_req,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_index,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              update,
    input  logic [IDX_W-1:0]  upd_index,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    input  logic [HIST_W-1:0] upd_hist
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] SWEEP_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    state_e             state_q;
    logic [IDX_W-1:0]   sweep_q;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic               pred_valid_q, pred_valid_d;
    logic               pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0]   pred_index_q, pred_index_d;
    logic [HIST_W-1:0]  pred_hist_q, pred_hist_d;
    logic [1:0]         pht_q [DEPTH];

    logic               run_s;
    logic               recover_s;
    logic               accept_s;
    logic [IDX_W-1:0]   ghr_ext_s;
    logic [IDX_W-1:0]   cat_s;
    logic [IDX_W-1:0]   idx_s;
    logic [1:0]         pred_ctr_s;
    logic               pht_we_s;
    logic [IDX_W-1:0]   pht_waddr_s;
    logic [1:0]         pht_wdata_s;
    logic               unused_s;

    // Only PC bits [IDX_W+1:2] and the low checkpoint bits feed the logic.
    assign unused_s = ^{pred_pc, upd_hist};

    assign ready      = (state_q == ST_RUN);
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_index = pred_index_q;
    assign pred_hist  = pred_hist_q;

    // Table index from the current GHR and the fetch PC (concat or XOR mode).
    always_comb begin
        ghr_ext_s                 = '0;
        ghr_ext_s[HIST_W-1:0]     = ghr_q;
        cat_s                     = '0;
        cat_s[IDX_W-1 -: HIST_W]  = ghr_q;
        for (int i = 0; i < IDX_W - HIST_W; i++) begin
            cat_s[i] = pred_pc[i + 2];
        end
        if (MODE == 1) begin
            idx_s = pred_pc[IDX_W+1:2] ^ ghr_ext_s;
        end else begin
            idx_s = cat_s;
        end
    end

    // Prediction acceptance, history recovery/speculation and output next state.
    always_comb begin
        run_s        = (state_q == ST_RUN);
        recover_s    = run_s & update & upd_mispredict;
        accept_s     = run_s & pred_req & ~recover_s;
        pred_ctr_s   = pht_q[idx_s];
        if (recover_s) begin
            ghr_d = {upd_hist[HIST_W-2:0], upd_taken};
        end else if (accept_s) begin
            ghr_d = {ghr_q[HIST_W-2:0], pred_ctr_s[1]};
        end else begin
            ghr_d = ghr_q;
        end
        if (accept_s) begin
            pred_valid_d = 1'b1;
            pred_taken_d = pred_ctr_s[1];
            pred_index_d = idx_s;
            pred_hist_d  = ghr_q;
        end else begin
            pred_valid_d = 1'b0;
            pred_taken_d = pred_taken_q;
            pred_index_d = pred_index_q;
            pred_hist_d  = pred_hist_q;
        end
    end

    // Single table write port: init sweep in INIT, training in RUN.
    always_comb begin
        if (state_q == ST_INIT) begin
            pht_we_s    = 1'b1;
            pht_waddr_s = sweep_q;
            pht_wdata_s = 2'b01;
        end else if (update) begin
            pht_we_s    = 1'b1;
            pht_waddr_s = upd_index;
            pht_wdata_s = sat_next(pht_q[upd_index], upd_taken);
        end else begin
            pht_we_s    = 1'b0;
            pht_waddr_s = '0;
            pht_wdata_s = 2'b00;
        end
    end

    // Counter table storage; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (pht_we_s) begin
            pht_q[pht_waddr_s] <= pht_wdata_s;
        end
    end

    // Init sweep FSM: walk every entry once, then stay in RUN until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + SWEEP_ONE;
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                    sweep_q <= '0;
                end
            endcase
        end
    end

    // History register and registered prediction outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
            pred_hist_q  <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor. Expected predictions are
// queued when a request is driven; a monitor pops and compares whenever the
// DUT raises pred_valid. A second instance checks concatenation mode.

module tb_gshare_branch_predictor;

    localparam int PC_W   = 16;
    localparam int HIST_W = 4;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic        taken;
        logic [3:0]  index;
        logic [3:0]  hist;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              ready;
    logic              pred_req;
    logic [PC_W-1:0]   pred_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [IDX_W-1:0]  pred_index;
    logic [HIST_W-1:0] pred_hist;
    logic              update;
    logic [IDX_W-1:0]  upd_index;
    logic              upd_taken;
    logic              upd_mispredict;
    logic [HIST_W-1:0] upd_hist;

    logic              m0_ready;
    logic              m0_pred_req;
    logic [PC_W-1:0]   m0_pred_pc;
    logic              m0_pred_valid;
    logic              m0_pred_taken;
    logic [IDX_W-1:0]  m0_pred_index;
    logic [HIST_W-1:0] m0_pred_hist;
    logic              m0_update;
    logic [IDX_W-1:0]  m0_upd_index;
    logic              m0_upd_taken;
    logic              m0_upd_mispredict;
    logic [HIST_W-1:0] m0_upd_hist;

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    gshare_branch_predictor #(.PC_W(PC_W), .HIST_W(HIST_W), .IDX_W(IDX_W), .MODE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_index(pred_index), .pred_hist(pred_hist),
        .update(update), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_hist(upd_hist)
    );

    gshare_branch_predictor #(.PC_W(PC_W), .HIST_W(HIST_W), .IDX_W(IDX_W), .MODE(0)) u_dut_m0 (
        .clk(clk), .rst_n(rst_n), .ready(m0_ready),
        .pred_req(m0_pred_req), .pred_pc(m0_pred_pc),
        .pred_valid(m0_pred_valid), .pred_taken(m0_pred_taken),
        .pred_index(m0_pred_index), .pred_hist(m0_pred_hist),
        .update(m0_update), .upd_index(m0_upd_index), .upd_taken(m0_upd_taken),
        .upd_mispredict(m0_upd_mispredict), .upd_hist(m0_upd_hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic t, input logic [3:0] i, input logic [3:0] h);
        exp_t e;
        e.taken = t;
        e.index = i;
        e.hist  = h;
        return e;
    endfunction

    // Monitor: every valid prediction must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && pred_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_valid: got pred_valid=1 (index 0x%0h), expected 0", pred_index);
            end else begin
                mon_e = exp_q.pop_front();
                check("pred_taken", {31'd0, pred_taken}, {31'd0, mon_e.taken});
                check("pred_index", {28'd0, pred_index}, {28'd0, mon_e.index});
                check("pred_hist",  {28'd0, pred_hist},  {28'd0, mon_e.hist});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic [15:0] pc, input exp_t e);
        pred_req = 1'b1;
        pred_pc  = pc;
        exp_q.push_back(e);
        tick();
        pred_req = 1'b0;
    endtask

    task automatic train(input logic [3:0] idx, input logic t);
        update         = 1'b1;
        upd_index      = idx;
        upd_taken      = t;
        upd_mispredict = 1'b0;
        tick();
        update = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pred_req = 1'b1; pred_pc = 16'h0010;
        update = 1'b0; upd_index = 4'd0; upd_taken = 1'b0; upd_mispredict = 1'b0; upd_hist = 4'd0;
        m0_pred_req = 1'b0; m0_pred_pc = 16'h0000;
        m0_update = 1'b0; m0_upd_index = 4'd0; m0_upd_taken = 1'b0;
        m0_upd_mispredict = 1'b0; m0_upd_hist = 4'd0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {31'd0, pred_valid}, 32'd0);
        check("rst_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_index", {28'd0, pred_index}, 32'd0);
        check("rst_hist",  {28'd0, pred_hist}, 32'd0);

        // Init sweep: requests ignored, ready after exactly 16 cycles
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 15) begin
                check("init_ready_low", {31'd0, ready}, 32'd0);
            end else begin
                check("init_ready_high", {31'd0, ready}, 32'd1);
                pred_req = 1'b0;
            end
        end

        // Basic prediction, ghr=0, weak not-taken
        predict(16'h0010, mk(1'b0, 4'd4, 4'd0));

        // Train entry 4 to strong taken, back-to-back requests
        train(4'd4, 1'b1);
        train(4'd4, 1'b1);
        predict(16'h0010, mk(1'b1, 4'd4, 4'd0));
        predict(16'h0010, mk(1'b0, 4'd5, 4'd1));

        // Saturation on entry 9 (ghr=0010 then 0101)
        repeat (4) train(4'd9, 1'b1);
        predict(16'h002C, mk(1'b1, 4'd9, 4'd2));
        repeat (5) train(4'd9, 1'b0);
        predict(16'h0030, mk(1'b0, 4'd9, 4'd5));

        // Same-cycle read and train of entry 9: prediction sees old counter 00
        pred_req = 1'b1; pred_pc = 16'h000C;
        update = 1'b1; upd_index = 4'd9; upd_taken = 1'b1; upd_mispredict = 1'b0;
        exp_q.push_back(mk(1'b0, 4'd9, 4'hA));
        tick();
        pred_req = 1'b0; update = 1'b0;
        train(4'd9, 1'b1);
        predict(16'h0034, mk(1'b1, 4'd9, 4'd4));

        // Mispredict recovery drops the concurrent request, ghr=1011
        pred_req = 1'b1; pred_pc = 16'h0010;
        update = 1'b1; upd_index = 4'd2; upd_taken = 1'b1;
        upd_mispredict = 1'b1; upd_hist = 4'b0101;
        tick();
        pred_req = 1'b0; update = 1'b0; upd_mispredict = 1'b0;
        tick();
        predict(16'h0010, mk(1'b0, 4'd15, 4'hB));
        tick();
        check("hold_valid", {31'd0, pred_valid}, 32'd0);
        check("hold_index", {28'd0, pred_index}, 32'd15);
        check("hold_hist",  {28'd0, pred_hist}, 32'd11);
        predict(16'h0010, mk(1'b1, 4'd2, 4'd6));
        tick();

        // Reset during RUN clears outputs immediately
        rst_n = 1'b0;
        #1;
        check("run_rst_ready", {31'd0, ready}, 32'd0);
        check("run_rst_taken", {31'd0, pred_taken}, 32'd0);
        check("run_rst_index", {28'd0, pred_index}, 32'd0);
        check("run_rst_hist",  {28'd0, pred_hist}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Reset again mid-sweep at entry 7, sweep restarts from 0
        repeat (7) tick();
        check("mid_sweep_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) check("reinit_ready_low", {31'd0, ready}, 32'd0);
            if (i == 15) check("reinit_ready_high", {31'd0, ready}, 32'd1);
        end
        predict(16'h0010, mk(1'b0, 4'd4, 4'd0));
        tick();

        // Concatenation mode: ghr=1011 via recovery, PC bits unused
        m0_update = 1'b1; m0_upd_mispredict = 1'b1; m0_upd_hist = 4'b0101;
        m0_upd_taken = 1'b1; m0_upd_index = 4'd0;
        tick();
        m0_update = 1'b0; m0_upd_mispredict = 1'b0;
        m0_pred_req = 1'b1; m0_pred_pc = 16'h0004;
        tick();
        m0_pred_req = 1'b0;
        check("m0_ready", {31'd0, m0_ready}, 32'd1);
        check("m0_valid", {31'd0, m0_pred_valid}, 32'd1);
        check("m0_index", {28'd0, m0_pred_index}, 32'd11);
        check("m0_hist",  {28'd0, m0_pred_hist}, 32'd11);
        check("m0_taken", {31'd0, m0_pred_taken}, 32'd0);

        repeat (2) tick();
        check("pending_expected", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
